// File: rtl/in_stream_unpacker_pkg.sv
// Shared definitions for the CGRA stream controllers: FSM encoding,
// a clog2 helper and the default memory-line / word geometry.
package in_stream_unpacker_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int DEFAULT_LINE_W = 512;
    localparam int DEFAULT_DATA_W = 16;

    // Ceiling log2 with a floor of 1 so index vectors are never zero-width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((32'sd1 << r) < v) r = r + 1;
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/in_stream_unpacker_line.sv
// Small synchronous line FIFO with a fall-through read port so a freshly
// pushed line can be popped on the following cycle.
module line_fifo
    import in_stream_unpacker_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [WIDTH-1:0]              din,
    input  logic                          pop,
    output logic [WIDTH-1:0]              dout,
    output logic [clog2(DEPTH+1)-1:0]     count,
    output logic                          empty,
    output logic                          full
);
    localparam int PW = clog2(DEPTH);
    localparam int CW = clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));
    assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/in_stream_unpacker.sv
// Input-stream controller: requests memory lines ahead of consumption, buffers
// them, and streams num_data DATA_W-bit words LSB-first to the CGRA port.
module in_stream_unpacker
    import in_stream_unpacker_pkg::*;
#(
    parameter int LINE_W     = DEFAULT_LINE_W,
    parameter int DATA_W     = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_data,
    input  logic              available_read,
    output logic              req_rd_data,
    input  logic              rd_valid,
    input  logic [LINE_W-1:0] rd_data,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic [CNT_W-1:0]  words_sent
);
    localparam int WPL   = LINE_W / DATA_W;
    localparam int IDX_W = clog2(WPL);
    localparam int CW    = clog2(FIFO_DEPTH + 1);
    localparam int OW    = CW + 2;

    state_e            state_q;
    logic [CNT_W-1:0]  total_q;
    logic [CNT_W-1:0]  lines_total_q;
    logic [CNT_W-1:0]  lines_req_q;
    logic [CNT_W-1:0]  words_sent_q;
    logic [CW-1:0]     outstanding_q;
    logic [LINE_W-1:0] line_q;
    logic              loaded_q;
    logic [IDX_W-1:0]  idx_q;
    logic [DATA_W-1:0] dout_q;
    logic              done_q;

    logic [LINE_W-1:0] fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              req;
    logic              xfer;
    logic              last_word;
    logic              end_of_line;
    logic [DATA_W-1:0] cur_words [WPL];

    for (genvar gi = 0; gi < WPL; gi++) begin : g_unpack
        assign cur_words[gi] = line_q[gi*DATA_W +: DATA_W];
    end

    // The loaded current line counts toward occupancy, so at most FIFO_DEPTH
    // lines are ever held or in flight.
    assign req = ~rst & (state_q == RUN) & start & available_read
               & (lines_req_q < lines_total_q)
               & ((OW'(outstanding_q) + OW'(fifo_count) + OW'(loaded_q)) < OW'(FIFO_DEPTH));

    assign dout_valid  = ~rst & (state_q == RUN) & loaded_q & start;
    assign xfer        = dout_valid & dout_ready;
    assign last_word   = xfer & ((words_sent_q + CNT_W'(1)) == total_q);
    assign end_of_line = xfer & (idx_q == IDX_W'(WPL - 1));
    assign push        = rd_valid & (outstanding_q != '0);
    assign pop         = ~rst & (state_q == RUN) & ~fifo_empty & ~last_word
                       & (~loaded_q | end_of_line);

    line_fifo #(.WIDTH(LINE_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (rd_data),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            total_q       <= '0;
            lines_total_q <= '0;
            lines_req_q   <= '0;
            words_sent_q  <= '0;
            outstanding_q <= '0;
            line_q        <= '0;
            loaded_q      <= 1'b0;
            idx_q         <= '0;
            dout_q        <= '0;
            done_q        <= 1'b0;
        end else begin
            outstanding_q <= outstanding_q + CW'(req) - CW'(push);
            lines_req_q   <= lines_req_q + CNT_W'(req);
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        total_q       <= num_data;
                        lines_total_q <= (num_data / CNT_W'(WPL))
                                       + CNT_W'((num_data % CNT_W'(WPL)) != '0);
                        if (num_data == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (xfer) words_sent_q <= words_sent_q + CNT_W'(1);
                    if (pop) begin
                        line_q   <= fifo_dout;
                        loaded_q <= 1'b1;
                        idx_q    <= '0;
                        dout_q   <= fifo_dout[DATA_W-1:0];
                    end else if (xfer) begin
                        if (end_of_line) begin
                            loaded_q <= 1'b0;
                        end else begin
                            idx_q  <= idx_q + 1'b1;
                            dout_q <= cur_words[idx_q + 1'b1];
                        end
                    end
                    // Any unread tail of the final line is dropped here.
                    if (last_word) begin
                        state_q  <= DONE;
                        done_q   <= 1'b1;
                        loaded_q <= 1'b0;
                    end
                end
                DONE: begin
                    loaded_q <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_rd_data = req;
    assign dout        = dout_q;
    assign done        = done_q;
    assign words_sent  = words_sent_q;

    assert property (@(posedge clk) disable iff (rst) !(rd_valid && outstanding_q == '0));

endmodule
